// File: rtl/control_puerta.sv
// Elevator door controller: sequences the door motor through open, hold, close,
// obstruction reversal and overweight lock-out, and drives the external door timer.
module control_puerta #(
  parameter int unsigned MOTION_CYCLES = 100,
  parameter int unsigned CW            = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] accion,
  input  logic       sensor_puerta,
  input  logic       sensor_sobrepeso,
  input  logic       t_expired,
  output logic       start_timer,
  output logic       restart_timer,
  output logic       motor_abrir,
  output logic       motor_cerrar,
  output logic       puerta_cerrada,
  output logic       alarma_sobrepeso,
  output logic [2:0] state
);

  localparam logic [CW-1:0] CNT_TOP = CW'(MOTION_CYCLES - 1);
  localparam logic [1:0]    ACC_ABRIR  = 2'b01;
  localparam logic [1:0]    ACC_CERRAR = 2'b10;

  typedef enum logic [2:0] {
    CERRADA      = 3'd0,
    ABRIENDO     = 3'd1,
    ABIERTA_ARM  = 3'd2,
    ABIERTA_WAIT = 3'd3,
    CERRANDO     = 3'd4,
    BLOQUEADA    = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_timer_d, restart_timer_d, motor_abrir_d, motor_cerrar_d;
  logic          puerta_cerrada_d, alarma_sobrepeso_d;

  assign state = state_q;

  // State, motion counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= CERRADA;
      cnt_q            <= '0;
      start_timer      <= 1'b0;
      restart_timer    <= 1'b0;
      motor_abrir      <= 1'b0;
      motor_cerrar     <= 1'b0;
      puerta_cerrada   <= 1'b1;
      alarma_sobrepeso <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      start_timer      <= start_timer_d;
      restart_timer    <= restart_timer_d;
      motor_abrir      <= motor_abrir_d;
      motor_cerrar     <= motor_cerrar_d;
      puerta_cerrada   <= puerta_cerrada_d;
      alarma_sobrepeso <= alarma_sobrepeso_d;
    end
  end

  // Next-state and motion counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CERRADA: begin
        if (accion == ACC_ABRIR) begin
          state_d = ABRIENDO;
          cnt_d   = CNT_TOP;
        end
      end
      ABRIENDO: begin
        if (cnt_q == '0) state_d = ABIERTA_ARM;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ABIERTA_ARM: state_d = ABIERTA_WAIT;
      ABIERTA_WAIT: begin
        if (sensor_sobrepeso) begin
          state_d = BLOQUEADA;
        end else if (sensor_puerta || accion == ACC_ABRIR) begin
          state_d = ABIERTA_ARM;
        end else if (t_expired || accion == ACC_CERRAR) begin
          state_d = CERRANDO;
          cnt_d   = CNT_TOP;
        end
      end
      CERRANDO: begin
        // Reversal reopens for exactly the distance already travelled
        if (sensor_puerta || sensor_sobrepeso || accion == ACC_ABRIR) begin
          state_d = ABRIENDO;
          cnt_d   = CNT_TOP - cnt_q;
        end else if (cnt_q == '0) begin
          state_d = CERRADA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      BLOQUEADA: begin
        if (!sensor_sobrepeso) state_d = ABIERTA_ARM;
      end
      default: state_d = CERRADA;
    endcase
  end

  // Output decode of the upcoming state, registered alongside it
  always_comb begin
    start_timer_d      = 1'b0;
    restart_timer_d    = 1'b0;
    motor_abrir_d      = 1'b0;
    motor_cerrar_d     = 1'b0;
    puerta_cerrada_d   = 1'b0;
    alarma_sobrepeso_d = 1'b0;
    motor_abrir_d      = (state_d == ABRIENDO);
    motor_cerrar_d     = (state_d == CERRANDO);
    start_timer_d      = (state_d == ABIERTA_ARM);
    puerta_cerrada_d   = (state_d == CERRADA);
    alarma_sobrepeso_d = (state_d == BLOQUEADA);
    restart_timer_d    = (state_q == ABIERTA_WAIT) && (state_d != ABIERTA_WAIT);
  end

endmodule
